slave_mem_ooo_model: RTL and testbench
======================================

Name: slave_mem_ooo_model

Overview:
- Parametrised behavioural slave memory for testbenches. Accepts read/write requests and returns read data out of order, tagged with transaction IDs.
- Reorder depth, TID width and minimum latency are configurable. Byte-enabled writes are supported.
- Response order is chosen by a seeded LFSR, so every run is reproducible. An in-order mode is available.
- Sits on the bus-slave side of DUT benches.

Parameters:
- MEMSIZE32, 1024: memory depth in 32-bit words; power of two.
- TID_W, 2: TID width; reorder buffer depth NSLOT = 2**TID_W (1..4).
- MIN_LAT, 1: minimum cycles from accept to response (1..15).
- REORDER_EN, 1: 1 = LFSR-selected out-of-order return; 0 = strict accept order.
- STALL_EN, 1: 1 = LFSR gate may idle a cycle even when a response is eligible.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit LFSR; must be non-zero.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- slave_req  in  1  request valid.
- slave_addr  in  32  byte address; word index = addr[2+:$clog2(MEMSIZE32)], upper bits ignored (wrap).
- slave_cmd  in  1  0 = read, 1 = write.
- slave_be  in  4  write byte enables.
- slave_wdata  in  32  write data.
- slave_ack  out  1  request accepted this cycle.
- slave_reqtid  out  TID_W  TID assigned to the accepted read.
- slave_resp  out  1  response valid.
- slave_resptid  out  TID_W  TID of the response.
- slave_rdata  out  32  response data.

Behaviour:
- Reset (rst_i low, async):
  - Slots free, ages 0, order queue empty, LFSR = LFSR_SEED.
  - Every memory word = 32'hdeadbeef.
  - slave_resp, slave_resptid and slave_rdata are 0.
- Acceptance:
  - slave_ack = slave_req & (slave_cmd | any slot free). Slot state used is the registered state only.
  - A slot freed this cycle is not reusable until the next cycle.
  - Writes are always acked, produce no response, and never occupy a slot.
- Write: on accept, each byte lane b with slave_be[b]=1 is updated at the clock edge. slave_be = 0 is a legal no-op.
- Read accept:
  - slave_reqtid = lowest-index free slot (combinational, valid only when ack & !cmd; 0 otherwise).
  - The slot captures mem[index] at the edge and is marked busy with age 0.
  - The TID is pushed to the order queue.
  - Data is snapshotted at accept: a later write to the same word does not alter the pending response.
- Aging: each busy slot's age increments every cycle, saturating at 15. A slot is eligible when age >= MIN_LAT - 1 (registered age), which gives an accept-to-resp latency >= MIN_LAT.
- Selection, each cycle:
  - gate = !STALL_EN | lfsr[15].
  - REORDER_EN=1: scan slots round-robin starting at lfsr[TID_W-1:0]; the first eligible slot wins.
  - REORDER_EN=0: the winner is the order-queue head, only if it is eligible.
- Response issue: if gate and a winner exists, the next edge:
  - sets slave_resp=1 with resptid/rdata from the slot;
  - frees the slot and pops it from the order queue (if in-order);
  - leaves the output registers driven for exactly one cycle.
  - Otherwise slave_resp=0, and resptid/rdata are 0.
- LFSR: Galois, taps 16,14,13,11; advances every cycle out of reset.
- Simultaneous read accept and response issue are allowed. The accepted read can never take the slot being freed, because allocation uses pre-edge state.
- Full condition: all NSLOT slots busy → reads are not acked (ack=0); writes are still acked.
- No backpressure on the response side; the consumer must always accept.
- Reset mid-transaction: all pending responses are discarded and memory is reinitialised.
- Order-queue depth = NSLOT; it cannot overflow because allocation is bounded by free slots.

Decomposition:
- Package slave_mem_pkg: DEADBEEF init constant, LFSR taps constant, slot struct {busy, age[3:0], rdata[31:0]}.
- Sub-module slave_mem_lfsr16: seedable 16-bit Galois LFSR with async active-low reset.
- Slot array, allocator, order queue and selector stay in the top level.

Test Plan:
- Reset, then read 0x0 → ack=1, reqtid=0; resp with rdata=32'hdeadbeef after >= MIN_LAT cycles, resptid=0.
- Write 0x10 data 0x11223344 be=4'b0101, then read 0x10 → rdata=0xde22be44.
- REORDER_EN=1, seed 16'hACE1: 4 back-to-back reads to 0x0,0x4,0x8,0xC with distinct prior writes → TIDs 0,1,2,3; a 5th read gets ack=0 until a response frees a slot. Each TID returns exactly once with matching data, and at least one pair returns out of order.
- REORDER_EN=0, STALL_EN=0, MIN_LAT=3: 3 reads in consecutive cycles → responses in accept order, first exactly 3 cycles after accept, on consecutive cycles.
- Read 0x20 (pending), write 0x20 = 0xCAFEF00D next cycle → pending response still returns 0xdeadbeef; a subsequent read returns 0xCAFEF00D.
- Pull rst_i low asynchronously with 2 reads pending → slave_resp=0 immediately, and no stale responses appear after release.

Source files
------------

// File: rtl/slave_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_mem_pkg : shared constants and slot record for the OoO model |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package slave_mem_pkg;

  localparam logic [31:0] MEM_INIT  = 32'hdeadbeef;
  // Galois right-shift mask for taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        busy;
    logic [3:0]  age;
    logic [31:0] rdata;
  } slot_t;

endpackage
`default_nettype wire

// File: rtl/slave_mem_lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_mem_lfsr16 : seedable free-running 16-bit Galois LFSR        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module slave_mem_lfsr16
  import slave_mem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/slave_mem_ooo_model.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_mem_ooo_model : behavioural slave memory, out-of-order reads |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module slave_mem_ooo_model
  import slave_mem_pkg::*;
#(
  parameter int unsigned MEMSIZE32  = 1024,
  parameter int unsigned TID_W      = 2,
  parameter int unsigned MIN_LAT    = 1,
  parameter bit          REORDER_EN = 1'b1,
  parameter bit          STALL_EN   = 1'b1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             slave_req,
  input  logic [31:0]      slave_addr,
  input  logic             slave_cmd,
  input  logic [3:0]       slave_be,
  input  logic [31:0]      slave_wdata,
  output logic             slave_ack,
  output logic [TID_W-1:0] slave_reqtid,
  output logic             slave_resp,
  output logic [TID_W-1:0] slave_resptid,
  output logic [31:0]      slave_rdata
);

  localparam int unsigned NSLOT = 2 ** TID_W;
  localparam int unsigned AW    = $clog2(MEMSIZE32);

  logic [31:0]      mem_q [MEMSIZE32];
  slot_t            slot_q [NSLOT];
  logic [TID_W-1:0] oq_q [NSLOT];
  logic [TID_W-1:0] oq_head_q, oq_tail_q;
  logic [TID_W:0]   oq_cnt_q;
  logic             resp_q;
  logic [TID_W-1:0] resptid_q;
  logic [31:0]      rdata_q;

  logic [15:0]      lfsr;
  logic [AW-1:0]    widx;
  logic [31:0]      wmerge;
  logic [NSLOT-1:0] elig;
  logic             any_free, win_vld, gate, issue, rd_acc, wr_acc, push, pop;
  logic [TID_W-1:0] free_idx, win_idx, scan_idx;
  logic             unused_bits;

  slave_mem_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .lfsr_o (lfsr)
  );

  assign widx      = slave_addr[2 +: AW];
  assign slave_ack = slave_req & (slave_cmd | any_free);
  assign rd_acc    = slave_ack & ~slave_cmd;
  assign wr_acc    = slave_ack & slave_cmd;
  assign slave_reqtid = rd_acc ? free_idx : '0;
  assign gate      = (STALL_EN == 1'b0) || lfsr[15];
  assign issue     = gate & win_vld;
  assign push      = rd_acc & (REORDER_EN == 1'b0);
  assign pop       = issue & (REORDER_EN == 1'b0);
  assign unused_bits = ^{slave_addr[31:AW+2], slave_addr[1:0], lfsr[14:TID_W]};

  // Descending scan leaves the lowest free index as the result
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!slot_q[i].busy) begin
        any_free = 1'b1;
        free_idx = TID_W'(i);
      end
    end
  end

  always_comb begin
    wmerge = mem_q[widx];
    for (int b = 0; b < 4; b++) begin
      if (slave_be[b]) wmerge[8*b +: 8] = slave_wdata[8*b +: 8];
    end
  end

  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    if (REORDER_EN) begin
      for (int k = 0; k < NSLOT; k++) begin
        scan_idx = lfsr[TID_W-1:0] + TID_W'(k);
        if (!win_vld && elig[scan_idx]) begin
          win_vld = 1'b1;
          win_idx = scan_idx;
        end
      end
    end else if (oq_cnt_q != '0 && elig[oq_q[oq_head_q]]) begin
      win_vld = 1'b1;
      win_idx = oq_q[oq_head_q];
    end
  end

  for (genvar w = 0; w < MEMSIZE32; w++) begin : g_mem
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                           mem_q[w] <= MEM_INIT;
      else if (wr_acc && widx == AW'(w))    mem_q[w] <= wmerge;
    end
  end

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    // Eligible once age+1 reaches MIN_LAT, i.e. the response edge is MIN_LAT after accept
    assign elig[s] = slot_q[s].busy && ((5'(slot_q[s].age) + 5'd1) >= 5'(MIN_LAT));

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        slot_q[s] <= '0;
      end else if (rd_acc && free_idx == TID_W'(s)) begin
        slot_q[s].busy  <= 1'b1;
        slot_q[s].age   <= 4'd0;
        slot_q[s].rdata <= mem_q[widx];
      end else if (issue && win_idx == TID_W'(s)) begin
        slot_q[s].busy <= 1'b0;
        slot_q[s].age  <= 4'd0;
      end else if (slot_q[s].busy && slot_q[s].age != 4'd15) begin
        slot_q[s].age <= slot_q[s].age + 4'd1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                oq_q[s] <= '0;
      else if (push && oq_tail_q == TID_W'(s))   oq_q[s] <= free_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      oq_head_q <= '0;
      oq_tail_q <= '0;
      oq_cnt_q  <= '0;
    end else begin
      if (push) oq_tail_q <= oq_tail_q + 1'b1;
      if (pop)  oq_head_q <= oq_head_q + 1'b1;
      oq_cnt_q <= oq_cnt_q + {{TID_W{1'b0}}, push} - {{TID_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_q    <= 1'b0;
      resptid_q <= '0;
      rdata_q   <= '0;
    end else begin
      resp_q    <= issue;
      resptid_q <= issue ? win_idx : '0;
      rdata_q   <= issue ? slot_q[win_idx].rdata : '0;
    end
  end

  assign slave_resp    = resp_q;
  assign slave_resptid = resptid_q;
  assign slave_rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_slave_mem_ooo_model.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_slave_mem_ooo_model : directed bench, OoO and in-order models   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_slave_mem_ooo_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_req, a_cmd, a_ack, a_resp;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic [1:0]  a_reqtid, a_resptid;
  logic        b_req, b_cmd, b_ack, b_resp;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic [1:0]  b_reqtid, b_resptid;

  slave_mem_ooo_model #(.MIN_LAT(4)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .slave_req(a_req), .slave_addr(a_addr), .slave_cmd(a_cmd),
    .slave_be(a_be), .slave_wdata(a_wdata), .slave_ack(a_ack), .slave_reqtid(a_reqtid),
    .slave_resp(a_resp), .slave_resptid(a_resptid), .slave_rdata(a_rdata));

  slave_mem_ooo_model #(.MIN_LAT(3), .REORDER_EN(1'b0), .STALL_EN(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .slave_req(b_req), .slave_addr(b_addr), .slave_cmd(b_cmd),
    .slave_be(b_be), .slave_wdata(b_wdata), .slave_ack(b_ack), .slave_reqtid(b_reqtid),
    .slave_resp(b_resp), .slave_resptid(b_resptid), .slave_rdata(b_rdata));

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // scoreboard for dut_a: pending reads keyed by TID
  logic        pend_v [4] = '{default: 1'b0};
  logic [31:0] pend_d [4];
  int          pend_seq [4];
  int          seq_n = 0;
  int          a_resp_n = 0;
  int          a_last_tid = 0;
  int          a_last_cyc = 0;
  bit          ooo_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n && a_resp) begin
      a_resp_n++;
      a_last_tid = int'(a_resptid);
      a_last_cyc = cyc;
      check("a_resp_was_pending", 32'(pend_v[a_resptid]), 32'd1);
      check("a_rdata", a_rdata, pend_d[a_resptid]);
      for (int t = 0; t < 4; t++)
        if (pend_v[t] && pend_seq[t] < pend_seq[a_resptid]) ooo_seen = 1'b1;
      pend_v[a_resptid] = 1'b0;
    end
  end

  int          b_n = 0;
  logic [1:0]  b_tid [8];
  logic [31:0] b_dat [8];
  int          b_cyc [8];
  always @(negedge clk) begin
    if (rst_n && b_resp) begin
      if (b_n < 8) begin
        b_tid[b_n] = b_resptid;
        b_dat[b_n] = b_rdata;
        b_cyc[b_n] = cyc;
      end
      b_n++;
    end
  end

  task automatic req(input bit sel, input bit cmd, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     output bit ack, output logic [1:0] tid, output int acc_cyc);
    @(negedge clk);
    if (!sel) begin a_req = 1'b1; a_cmd = cmd; a_addr = addr; a_be = be; a_wdata = wd; end
    else      begin b_req = 1'b1; b_cmd = cmd; b_addr = addr; b_be = be; b_wdata = wd; end
    #1;
    ack = sel ? b_ack : a_ack;
    tid = sel ? b_reqtid : a_reqtid;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!sel && ack && !cmd) begin
      pend_v[tid]   = 1'b1;
      pend_d[tid]   = exp_rd;
      pend_seq[tid] = seq_n++;
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((pend_v[0] | pend_v[1] | pend_v[2] | pend_v[3]) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check(tag, 32'(pend_v[0]) + 32'(pend_v[1]) + 32'(pend_v[2]) + 32'(pend_v[3]), 32'd0);
  endtask

  logic [31:0] exp_w [4];
  bit          ack;
  logic [1:0]  tid;
  int          ac, ac0, n0, n;

  initial begin
    exp_w = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    a_req = 0; a_cmd = 0; a_addr = 0; a_be = 0; a_wdata = 0;
    b_req = 0; b_cmd = 0; b_addr = 0; b_be = 0; b_wdata = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp", 32'(a_resp), 32'd0);
    check("rst_resptid", 32'(a_resptid), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    check("rst_b_resp", 32'(b_resp), 32'd0);
    rst_n = 1'b1;

    // first read after reset returns the init pattern
    req(0, 0, 32'h0, 4'h0, 32'h0, 32'hdeadbeef, ack, tid, ac);
    check("t1_ack", 32'(ack), 32'd1);
    check("t1_reqtid", 32'(tid), 32'd0);
    n0 = a_resp_n; n = 0;
    while (a_resp_n < n0 + 1 && n < 100) begin @(negedge clk); #1; n++; end
    check("t1_resp_seen", 32'(a_resp_n), 32'(n0 + 1));
    check("t1_resptid", 32'(a_last_tid), 32'd0);
    check("t1_latency_ge_min", 32'(a_last_cyc - ac >= 4), 32'd1);

    // byte-enabled write merge
    req(0, 1, 32'h10, 4'b0101, 32'h11223344, 32'h0, ack, tid, ac);
    check("t2_wr_ack", 32'(ack), 32'd1);
    req(0, 0, 32'h10, 4'h0, 32'h0, 32'hde22be44, ack, tid, ac);
    wait_drain("t2_drain");

    // fill all four slots, fifth read must stall
    for (int i = 0; i < 4; i++) req(0, 1, 32'(i * 4), 4'hf, exp_w[i], 32'h0, ack, tid, ac);
    for (int i = 0; i < 4; i++) begin
      req(0, 0, 32'(i * 4), 4'h0, 32'h0, exp_w[i], ack, tid, ac);
      check("t3_ack", 32'(ack), 32'd1);
      check("t3_tid", 32'(tid), 32'(i));
    end
    req(0, 0, 32'h0, 4'h0, 32'h0, exp_w[0], ack, tid, ac);
    check("t3_fifth_blocked", 32'(ack), 32'd0);
    n = 0;
    while (!ack && n < 40) begin
      req(0, 0, 32'h0, 4'h0, 32'h0, exp_w[0], ack, tid, ac);
      n++;
    end
    check("t3_fifth_acked", 32'(ack), 32'd1);
    wait_drain("t3_drain");
    for (int bt = 0; bt < 6; bt++) begin
      if (!ooo_seen) begin
        for (int i = 0; i < 4; i++) begin
          req(0, 0, 32'(i * 4), 4'h0, 32'h0, exp_w[i], ack, tid, ac);
          check("t3_batch_ack", 32'(ack), 32'd1);
        end
        wait_drain("t3_batch_drain");
      end
    end
    check("t3_out_of_order", 32'(ooo_seen), 32'd1);

    // read data is snapshotted at accept
    req(0, 0, 32'h20, 4'h0, 32'h0, 32'hdeadbeef, ack, tid, ac);
    req(0, 1, 32'h20, 4'hf, 32'hCAFEF00D, 32'h0, ack, tid, ac);
    wait_drain("t5_drain_old");
    req(0, 0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, ack, tid, ac);
    wait_drain("t5_drain_new");

    // in-order instance, MIN_LAT=3, no stall
    for (int i = 0; i < 3; i++) req(1, 1, 32'(i * 4), 4'hf, exp_w[i], 32'h0, ack, tid, ac);
    for (int i = 0; i < 3; i++) begin
      req(1, 0, 32'(i * 4), 4'h0, 32'h0, 32'h0, ack, tid, ac);
      if (i == 0) ac0 = ac;
      check("b_ack", 32'(ack), 32'd1);
      check("b_reqtid", 32'(tid), 32'(i));
    end
    n = 0;
    while (b_n < 3 && n < 50) begin @(negedge clk); #1; n++; end
    repeat (10) @(negedge clk);
    #1;
    check("b_resp_count", 32'(b_n), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check("b_resptid", 32'(b_tid[k]), 32'(k));
      check("b_rdata", b_dat[k], exp_w[k]);
      check("b_latency", 32'(b_cyc[k] - ac0), 32'(3 + k));
    end

    // async reset with reads pending
    for (int i = 0; i < 3; i++) req(0, 0, 32'(i * 4), 4'h0, 32'h0, exp_w[i], ack, tid, ac);
    n = 0;
    while (!a_resp && n < 100) begin @(negedge clk); n++; end
    check("t6_resp_before_reset", 32'(a_resp), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_resp", 32'(a_resp), 32'd0);
    check("t6_async_rdata", a_rdata, 32'd0);
    for (int t = 0; t < 4; t++) pend_v[t] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = a_resp_n;
    repeat (20) @(negedge clk);
    #1;
    check("t6_no_stale", 32'(a_resp_n), 32'(n0));
    req(0, 0, 32'h0, 4'h0, 32'h0, 32'hdeadbeef, ack, tid, ac);
    check("t6_reqtid_after_reset", 32'(tid), 32'd0);
    wait_drain("t6_drain_reinit");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
